pcf8563_responder: RTL

- I2C target that emulates a PCF8563 RTC on the IIC pins. It is the bus-side counterpart of the pcf8563_if initiator.
- It holds a 16-byte register file (addresses 0x00–0x0F) and answers the standard PCF8563 sequences: pointer write, data write, and auto-incrementing read with repeated START.
- Used as a synthesizable loopback and test target in the APDAQ IIC subsystem. A local port lets firmware or a bench preload and inspect the registers.

---
 rtl/pcf8563_responder.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pcf8563_responder.sv
// PCF8563-compatible I2C target with a 16-byte register file and a local preload/inspect port.
// Optional once-per-second seconds/minutes update when PCF8563_RESPONDER_TICK_EN is defined.
module pcf8563_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h51,
    parameter int         FILTER_LEN = 3,
    parameter int         CLK_FREQ   = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    input  logic       loc_we,
    input  logic [3:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam int FCW = $clog2(FILTER_LEN + 1);

    if (FILTER_LEN < 1 || CLK_FREQ < 2) begin : g_param_check
        $error("pcf8563_responder: FILTER_LEN must be >= 1 and CLK_FREQ >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WR, S_RD, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t         r_state;
    logic [1:0]     r_scl_sync, r_sda_sync;
    logic           r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;
    logic [FCW-1:0] r_scl_cnt, r_sda_cnt;
    logic [3:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic [3:0]     r_ptr;
    logic           r_rw;
    logic           r_sda_t;
    logic           r_busy;
    logic           r_wr_strobe;
    logic [3:0]     r_wr_addr;
    logic [7:0]     r_wr_data;
    logic [7:0]     r_loc_rdata;
    logic [7:0]     r_regs [16];

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_bus_we;

    // A filtered level only flips after FILTER_LEN consecutive opposite synchronized samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_fd   <= 1'b1;
            r_sda_fd   <= 1'b1;
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_fd   <= r_scl_f;
            r_sda_fd   <= r_sda_f;
            if (r_scl_sync[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FCW'(FILTER_LEN - 1)) begin
                r_scl_f   <= r_scl_sync[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 1'b1;
            end
            if (r_sda_sync[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FCW'(FILTER_LEN - 1)) begin
                r_sda_f   <= r_sda_sync[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 1'b1;
            end
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_fd;
    assign w_scl_fall = ~r_scl_f & r_scl_fd;
    assign w_start    = r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;
    assign w_bus_we   = en & ~w_start & ~w_stop & (r_state == S_WR) &
                        (r_bit_cnt == 4'd9) & w_scl_rise;

    // r_bit_cnt: 0..8 data bits received, 9 = inside the ACK slot.
    always_ff @(posedge clk) begin
        r_wr_strobe <= 1'b0;
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_sda_t   <= 1'b1;
            r_busy    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (!en) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_sda_t   <= 1'b1;
            r_busy    <= 1'b0;
        end else if (w_start) begin
            r_state   <= S_ADDR;
            r_bit_cnt <= '0;
            r_sda_t   <= 1'b1;
        end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_sda_t   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise && r_bit_cnt < 4'd8) begin
                        r_shift   <= {r_shift[6:0], r_sda_f};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_shift[7:1] == DEV_ADDR) begin
                            r_state <= S_ADDR_ACK;
                            r_sda_t <= 1'b0;
                            r_busy  <= 1'b1;
                            r_rw    <= r_shift[0];
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            r_state   <= S_RD;
                            r_shift   <= r_regs[r_ptr];
                            r_sda_t   <= r_regs[r_ptr][7];
                            r_bit_cnt <= 4'd1;
                        end else begin
                            r_state   <= S_PTR;
                            r_sda_t   <= 1'b1;
                            r_bit_cnt <= '0;
                        end
                    end
                end
                S_PTR, S_WR: begin
                    if (w_scl_rise) begin
                        if (r_bit_cnt < 4'd8) begin
                            r_shift   <= {r_shift[6:0], r_sda_f};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (r_bit_cnt == 4'd9) begin
                            if (r_state == S_PTR) begin
                                r_ptr <= r_shift[3:0];
                            end else begin
                                r_wr_strobe <= 1'b1;
                                r_wr_addr   <= r_ptr;
                                r_wr_data   <= r_shift;
                                r_ptr       <= r_ptr + 4'd1;
                            end
                        end
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            r_sda_t   <= 1'b0;
                            r_bit_cnt <= 4'd9;
                        end else if (r_bit_cnt == 4'd9) begin
                            r_sda_t   <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            r_sda_t <= 1'b1;
                            r_state <= S_RD_ACK;
                        end else begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_sda_t   <= r_shift[6];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        r_ptr <= r_ptr + 4'd1;
                        if (r_sda_f) r_state <= S_WAIT_STOP;
                        else         r_bit_cnt <= 4'd9;
                    end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
                        r_state   <= S_RD;
                        r_shift   <= r_regs[r_ptr];
                        r_sda_t   <= r_regs[r_ptr][7];
                        r_bit_cnt <= 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PCF8563_RESPONDER_TICK_EN
    localparam int TCW = $clog2(CLK_FREQ);
    logic [TCW-1:0] r_tick_cnt;
    logic           r_tick_pend;
    logic           w_tick_due;
    logic           w_sec_write;

    assign w_tick_due  = (r_tick_cnt == TCW'(CLK_FREQ - 1)) | r_tick_pend;
    assign w_sec_write = (loc_we & (loc_addr == 4'h2)) | (w_bus_we & (r_ptr == 4'h2));

    // BCD 00..59 increment on bits [6:0]; bit 7 passes through untouched.
    function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
        if (v[6:0] == 7'h59)    return {v[7], 7'h00};
        else if (v[3:0] == 4'h9) return {v[7], v[6:4] + 3'd1, 4'h0};
        else                     return {v[7], v[6:4], v[3:0] + 4'd1};
    endfunction
`endif

    // Later assignments win: tick, then local write, then bus commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
            r_loc_rdata <= 8'h00;
`ifdef PCF8563_RESPONDER_TICK_EN
            r_tick_cnt  <= '0;
            r_tick_pend <= 1'b0;
`endif
        end else begin
            r_loc_rdata <= r_regs[loc_addr];
`ifdef PCF8563_RESPONDER_TICK_EN
            if (w_tick_due && !r_busy) begin
                r_regs[2] <= bcd_inc59(r_regs[2]);
                if (r_regs[2][6:0] == 7'h59) r_regs[3] <= bcd_inc59(r_regs[3]);
                r_tick_pend <= 1'b0;
            end else if (w_tick_due) begin
                r_tick_pend <= 1'b1;
            end
            if (w_sec_write || r_tick_cnt == TCW'(CLK_FREQ - 1)) r_tick_cnt <= '0;
            else r_tick_cnt <= r_tick_cnt + 1'b1;
`endif
            if (loc_we)   r_regs[loc_addr] <= loc_wdata;
            if (w_bus_we) r_regs[r_ptr]    <= r_shift;
        end
    end

    assign scl_o     = 1'b1;
    assign scl_t     = 1'b1;
    assign sda_o     = 1'b0;
    assign sda_t     = r_sda_t;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign loc_rdata = r_loc_rdata;
endmodule
